// File: rtl/riscv_ctl_pkg.sv
// Shared state encodings and constants for the core execution sequencer.
package riscv_ctl_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_PAUSED  = 3'd3;
  localparam logic [2:0] S_STEP    = 3'd4;
  localparam logic [2:0] S_BREAK   = 3'd5;
  localparam logic [2:0] S_TIMEOUT = 3'd6;

  // SYSTEM opcode; EBREAK is the SYSTEM instruction with imm=1.
  localparam logic [6:0] OPC_EBREAK = 7'b1110011;

endpackage

// File: rtl/run_controller_sat_counter.sv
// W-bit counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/run_controller.sv
// Execution sequencer for the single-cycle core: owns its reset and run enable,
// supports pause/step/resume, and stops on EBREAK or an optional cycle budget.
module run_controller
  import riscv_ctl_pkg::*;
#(
  parameter int W          = 32,
  parameter int RST_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         halt_req,
  input  logic         resume,
  input  logic         step,
  input  logic         brk,
  input  logic [W-1:0] max_cycles,
  output logic         core_rst,
  output logic         run,
  output logic         busy,
  output logic         done,
  output logic         timeout,
  output logic [W-1:0] cycle_cnt,
  output logic [W-1:0] instret,
  output logic [2:0]   state
);

  localparam int CW = $clog2(RST_CYCLES) + 1;
  localparam logic [CW-1:0] CLR_LAST = CW'(RST_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] clr_cnt_q;
  logic          done_q;
  logic          hit;
  logic          cnt_clr;

  // Budget is compared live so a host can tighten or relax it mid-run.
  assign hit = (max_cycles != '0) && (cycle_cnt == max_cycles);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_CLEAR;
      S_CLEAR:   if (clr_cnt_q == CLR_LAST) state_d = S_RUN;
      S_RUN: begin
        if (brk)           state_d = S_BREAK;
        else if (hit)      state_d = S_TIMEOUT;
        else if (halt_req) state_d = S_PAUSED;
      end
      S_PAUSED: begin
        if (start)       state_d = S_CLEAR;
        else if (step)   state_d = S_STEP;
        else if (resume) state_d = S_RUN;
      end
      S_STEP: begin
        if (brk)      state_d = S_BREAK;
        else if (hit) state_d = S_TIMEOUT;
        else          state_d = S_PAUSED;
      end
      S_BREAK, S_TIMEOUT: if (start) state_d = S_CLEAR;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs are gated by rst so a reset aborts the core in the same cycle.
  always_comb begin
    core_rst = rst || (state_q == S_CLEAR);
    run      = !rst && ((state_q == S_RUN) || (state_q == S_STEP)) && !brk && !hit;
    busy     = !rst && ((state_q == S_CLEAR) || (state_q == S_RUN) || (state_q == S_STEP));
    timeout  = !rst && (state_q == S_TIMEOUT);
    done     = !rst && done_q;
    state    = state_q;
  end

  always_ff @(posedge clk) begin
    if (rst || (state_q != S_CLEAR)) begin
      clr_cnt_q <= '0;
    end else begin
      clr_cnt_q <= clr_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_d == S_BREAK) && (state_q != S_BREAK);
    end
  end

  assign cnt_clr = rst || (state_q == S_CLEAR);

  // run already implies RUN/STEP, so both counters share one enable.
  sat_counter #(.W(W)) u_cycle_cnt (
    .clk (clk),
    .clr (cnt_clr),
    .en  (run),
    .cnt (cycle_cnt)
  );

  sat_counter #(.W(W)) u_instret (
    .clk (clk),
    .clr (cnt_clr),
    .en  (run),
    .cnt (instret)
  );

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller with a tiny PC/imem model supplying brk.
module tb_run_controller;
  import riscv_ctl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, halt_req, resume, step, force_brk;
  logic        brk;
  logic [31:0] max_cycles;
  logic        core_rst, run, busy, done, timeout;
  logic [31:0] cycle_cnt, instret;
  logic [2:0]  state;

  logic [31:0] pc;
  logic [31:0] imem [16];
  logic [31:0] cur_word;

  logic       sc_clr, sc_en;
  logic [2:0] sc_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  run_controller #(.W(32), .RST_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .halt_req   (halt_req),
    .resume     (resume),
    .step       (step),
    .brk        (brk),
    .max_cycles (max_cycles),
    .core_rst   (core_rst),
    .run        (run),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .cycle_cnt  (cycle_cnt),
    .instret    (instret),
    .state      (state)
  );

  sat_counter #(.W(3)) u_sat (
    .clk (clk),
    .clr (sc_clr),
    .en  (sc_en),
    .cnt (sc_cnt)
  );

  // Core model: PC cleared by core_rst, advances one word per run cycle.
  always @(posedge clk) begin
    if (core_rst) pc <= 32'd0;
    else if (run) pc <= pc + 32'd4;
  end

  always_comb begin
    cur_word = imem[pc[5:2]];
    brk      = force_brk | (cur_word[6:0] == OPC_EBREAK);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; resume = 1'b0; step = 1'b0;
    force_brk = 1'b0; max_cycles = 32'd0; sc_clr = 1'b1; sc_en = 1'b0;
    for (int i = 0; i < 16; i++) imem[i] = 32'h0000_0013;
    imem[3] = 32'h0010_0073;

    // 1: reset, then start through a 2-cycle CLEAR
    tick(); tick();
    check("rst_state", 32'(state), 32'(S_IDLE));
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_run", 32'(run), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cycle_cnt", cycle_cnt, 32'd0);
    check("rst_instret", instret, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_core_rst", 32'(core_rst), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    check("clr1_state", 32'(state), 32'(S_CLEAR));
    check("clr1_core_rst", 32'(core_rst), 32'd1);
    check("clr1_busy", 32'(busy), 32'd1);
    tick();
    check("clr2_state", 32'(state), 32'(S_CLEAR));
    check("clr2_core_rst", 32'(core_rst), 32'd1);
    tick();
    check("run_state", 32'(state), 32'(S_RUN));
    check("run_core_rst", 32'(core_rst), 32'd0);
    check("run_run", 32'(run), 32'd1);

    // 2: EBREAK at word 3
    tick(); check("brk_run_pc4", 32'(run), 32'd1);
    tick(); check("brk_run_pc8", 32'(run), 32'd1);
    tick();
    check("brk_run_low", 32'(run), 32'd0);
    check("brk_pc", pc, 32'd12);
    tick();
    check("brk_state", 32'(state), 32'(S_BREAK));
    check("brk_done", 32'(done), 32'd1);
    check("brk_instret", instret, 32'd3);
    check("brk_timeout", 32'(timeout), 32'd0);
    check("brk_busy", 32'(busy), 32'd0);
    step = 1'b1; tick(); step = 1'b0;
    check("brk_done_once", 32'(done), 32'd0);
    check("brk_step_ignored", 32'(state), 32'(S_BREAK));
    check("brk_pc_hold", pc, 32'd12);

    // 3: cycle budget of 10 on a NOP loop
    imem[3] = 32'h0000_0013;
    max_cycles = 32'd10;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("to_run_state", 32'(state), 32'(S_RUN));
    check("to_cnt_zero", cycle_cnt, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    check("to_hit_run", 32'(run), 32'd0);
    check("to_hit_cnt", cycle_cnt, 32'd10);
    tick();
    check("to_state", 32'(state), 32'(S_TIMEOUT));
    check("to_timeout", 32'(timeout), 32'd1);
    check("to_instret", instret, 32'd10);
    check("to_run", 32'(run), 32'd0);
    resume = 1'b1; tick(); resume = 1'b0;
    check("to_resume_ignored", 32'(state), 32'(S_TIMEOUT));
    check("to_cnt_hold", cycle_cnt, 32'd10);
    max_cycles = 32'd0;
    start = 1'b1; tick(); start = 1'b0;
    check("to_restart_state", 32'(state), 32'(S_CLEAR));
    tick();
    check("to_restart_cnt", cycle_cnt, 32'd0);
    check("to_restart_instret", instret, 32'd0);
    tick();
    check("to_restart_run", 32'(state), 32'(S_RUN));

    // 4: halt in run cycle 5, then three spaced steps
    for (int i = 0; i < 4; i++) tick();
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    check("halt_state", 32'(state), 32'(S_PAUSED));
    check("halt_cnt", cycle_cnt, 32'd5);
    check("halt_run", 32'(run), 32'd0);
    for (int s = 0; s < 3; s++) begin
      step = 1'b1; tick(); step = 1'b0;
      check("step_state", 32'(state), 32'(S_STEP));
      tick();
      check("step_paused", 32'(state), 32'(S_PAUSED));
      check("step_instret", instret, 32'(6 + s));
      tick();
    end
    resume = 1'b1; tick(); resume = 1'b0;
    check("resume_state", 32'(state), 32'(S_RUN));
    check("resume_cnt", cycle_cnt, 32'd8);

    // 5: simultaneous events
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    step = 1'b1; resume = 1'b1; tick(); step = 1'b0; resume = 1'b0;
    check("step_resume_state", 32'(state), 32'(S_STEP));
    tick();
    resume = 1'b1; tick(); resume = 1'b0;
    check("resume2_cnt", cycle_cnt, 32'd10);
    start = 1'b1; tick(); start = 1'b0;
    check("start_in_run_state", 32'(state), 32'(S_RUN));
    check("start_in_run_cnt", cycle_cnt, 32'd11);
    tick();
    force_brk = 1'b1; halt_req = 1'b1; #1;
    check("halt_brk_run", 32'(run), 32'd0);
    tick(); force_brk = 1'b0; halt_req = 1'b0;
    check("halt_brk_state", 32'(state), 32'(S_BREAK));
    check("halt_brk_done", 32'(done), 32'd1);
    check("halt_brk_instret", instret, 32'd12);

    // 6: reset mid-RUN and mid-STEP
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    check("mr_cnt", cycle_cnt, 32'd3);
    rst = 1'b1; #1;
    check("mr_run", 32'(run), 32'd0);
    check("mr_core_rst", 32'(core_rst), 32'd1);
    tick();
    check("mr_state", 32'(state), 32'(S_IDLE));
    check("mr_cnt0", cycle_cnt, 32'd0);
    check("mr_done", 32'(done), 32'd0);
    tick();
    check("mr_busy", 32'(busy), 32'd0);
    rst = 1'b0; tick();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    step = 1'b1; tick(); step = 1'b0;
    check("ms_state_step", 32'(state), 32'(S_STEP));
    rst = 1'b1; #1;
    check("ms_run", 32'(run), 32'd0);
    tick();
    check("ms_state", 32'(state), 32'(S_IDLE));
    check("ms_instret", instret, 32'd0);
    check("ms_done", 32'(done), 32'd0);
    rst = 1'b0; tick();
    check("ms_idle_hold", 32'(state), 32'(S_IDLE));

    // Saturation on a 3-bit counter: 9 enables stick at 7
    tick(); sc_clr = 1'b0; sc_en = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("sat_mid", 32'(sc_cnt), 32'd6);
    for (int i = 0; i < 3; i++) tick();
    check("sat_top", 32'(sc_cnt), 32'd7);
    sc_en = 1'b0; sc_clr = 1'b1; tick();
    check("sat_clr", 32'(sc_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
